// File: rtl/varset_shadow_bank.sv
// Avalon-MM bank of input snapshots and double-buffered output variables.
// Captures and commits are triggered by software or by a synchronised external strobe.
module varset_shadow_bank #(
    parameter int unsigned N_VAR   = 60,
    parameter int unsigned DW      = 32,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [7:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic [3:0]          avs_byteenable,
    output logic [31:0]         avs_readdata,
    input  logic [N_VAR*DW-1:0] i_var,
    output logic [N_VAR*DW-1:0] o_reg,
    output logic                o_upd,
    input  logic                sync_in
);

    localparam logic [DW-1:0] RST_W = RST_VAL[DW-1:0];

    logic [DW-1:0] r_snap   [N_VAR];
    logic [DW-1:0] r_shadow [N_VAR];
    logic [DW-1:0] r_oreg   [N_VAR];
    logic [1:0]    r_ctrl;
    logic [15:0]   r_snap_cnt;
    logic          r_dirty, r_fresh, r_upd;
    logic [31:0]   r_readdata;
    logic          r_sync1, r_sync2, r_sync3, r_sync_pulse;

    logic [1:0]    w_region;
    logic [5:0]    w_idx;
    logic          w_idx_ok;
    logic          w_wr_ctrl, w_sw_snap, w_sw_commit;
    logic          w_snap, w_commit, w_wr_shadow, w_rd_status;
    logic [31:0]   w_wmask32;
    logic [DW-1:0] w_wmask, w_wdata;
    logic [31:0]   w_rdata;

    assign w_region    = avs_address[7:6];
    assign w_idx       = avs_address[5:0];
    assign w_idx_ok    = ({26'd0, w_idx} < N_VAR);
    assign w_wr_ctrl   = avs_write && (avs_address == 8'h00);
    assign w_sw_snap   = w_wr_ctrl && avs_byteenable[1] && avs_writedata[8];
    assign w_sw_commit = w_wr_ctrl && avs_byteenable[1] && avs_writedata[9];
    // SW and sync triggers merge into a single action per edge
    assign w_snap      = w_sw_snap || (r_sync_pulse && r_ctrl[0]);
    assign w_commit    = w_sw_commit || (r_sync_pulse && r_ctrl[1]);
    assign w_wr_shadow = avs_write && (w_region == 2'b10) && w_idx_ok;
    assign w_rd_status = avs_read && (avs_address == 8'h01);
    assign w_wmask32   = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                          {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign w_wmask     = w_wmask32[DW-1:0];
    assign w_wdata     = avs_writedata[DW-1:0];

    always_comb begin
        w_rdata = '0;
        case (w_region)
            2'b00: begin
                case (w_idx)
                    6'd0:    w_rdata = {30'd0, r_ctrl};
                    6'd1:    w_rdata = {30'd0, r_fresh, r_dirty};
                    6'd2:    w_rdata = {16'd0, r_snap_cnt};
                    default: w_rdata = '0;
                endcase
            end
            2'b01:   if (w_idx_ok) w_rdata = 32'(r_snap[w_idx]);
            2'b10:   if (w_idx_ok) w_rdata = 32'(r_shadow[w_idx]);
            default: w_rdata = '0;
        endcase
    end

    // Two synchroniser flops, edge-detect flop, then a registered pulse
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_sync_pulse <= 1'b0;
        end else begin
            r_sync1      <= sync_in;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            r_sync_pulse <= r_sync2 & ~r_sync3;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ctrl     <= 2'b00;
            r_snap_cnt <= 16'd0;
            r_dirty    <= 1'b0;
            r_fresh    <= 1'b0;
            r_upd      <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            if (w_wr_ctrl && avs_byteenable[0]) r_ctrl <= avs_writedata[1:0];
            if (w_snap) r_snap_cnt <= r_snap_cnt + 16'd1;
            if (w_snap) r_fresh <= 1'b1;
            else if (w_rd_status) r_fresh <= 1'b0;
            // A write racing a commit leaves the bank dirty
            if (w_wr_shadow) r_dirty <= 1'b1;
            else if (w_commit) r_dirty <= 1'b0;
            r_upd <= w_commit;
            if (avs_read) r_readdata <= w_rdata;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned i = 0; i < N_VAR; i++) begin
                r_snap[i]   <= '0;
                r_shadow[i] <= RST_W;
                r_oreg[i]   <= RST_W;
            end
        end else begin
            if (w_snap) begin
                for (int unsigned i = 0; i < N_VAR; i++) r_snap[i] <= i_var[i*DW +: DW];
            end
            if (w_commit) begin
                for (int unsigned i = 0; i < N_VAR; i++) r_oreg[i] <= r_shadow[i];
            end
            if (w_wr_shadow) begin
                r_shadow[w_idx] <= (r_shadow[w_idx] & ~w_wmask) | (w_wdata & w_wmask);
            end
        end
    end

    for (genvar g = 0; g < N_VAR; g++) begin : g_out
        assign o_reg[g*DW +: DW] = r_oreg[g];
    end

    assign o_upd        = r_upd;
    assign avs_readdata = r_readdata;

endmodule

// File: tb/tb_varset_shadow_bank.sv
// Self-checking bench for varset_shadow_bank: register reads are scoreboarded,
// output-side state is checked directly.
module tb_varset_shadow_bank;

    localparam int unsigned N_VAR   = 60;
    localparam logic [31:0] RST_VAL = 32'hC0DE_0001;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n = 1'b0;
    logic [7:0]          avs_address = '0;
    logic                avs_read = 1'b0;
    logic                avs_write = 1'b0;
    logic [31:0]         avs_writedata = '0;
    logic [3:0]          avs_byteenable = '0;
    logic [31:0]         avs_readdata, rd16;
    logic [N_VAR*32-1:0] i_var = '0;
    logic [N_VAR*32-1:0] o_reg;
    logic [N_VAR*16-1:0] i_var16 = '0;
    logic [N_VAR*16-1:0] o_reg16;
    logic                o_upd, upd16;
    logic                sync_in = 1'b0;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    logic [31:0] sb_exp[$];
    string       sb_tag[$];

    always #5 clk_clk = ~clk_clk;

    varset_shadow_bank #(.N_VAR(N_VAR), .DW(32), .RST_VAL(RST_VAL)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata), .i_var(i_var),
        .o_reg(o_reg), .o_upd(o_upd), .sync_in(sync_in)
    );

    varset_shadow_bank #(.N_VAR(N_VAR), .DW(16), .RST_VAL(32'h0)) dut16 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable), .avs_readdata(rd16), .i_var(i_var16),
        .o_reg(o_reg16), .o_upd(upd16), .sync_in(sync_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk_clk);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        @(posedge clk_clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk_clk);
        avs_address = a; avs_read = 1'b1;
        sb_exp.push_back(exp); sb_tag.push_back(tag);
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        chk(sb_tag.pop_front(), avs_readdata, sb_exp.pop_front());
    endtask

    // Raise sync_in so edge k samples it; returns just after edge k+2
    task automatic sync_to_k2();
        @(negedge clk_clk); sync_in = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
    endtask

    task automatic sync_drop();
        @(negedge clk_clk); sync_in = 1'b0;
        repeat (5) @(posedge clk_clk);
    endtask

    function automatic logic [31:0] oreg_w(input int unsigned i);
        return o_reg[i*32 +: 32];
    endfunction

    initial begin
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_oreg5", oreg_w(5), RST_VAL);
        chk("rst_upd", {31'd0, o_upd}, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        @(negedge clk_clk); reset_reset_n = 1'b1;
        bus_read(8'h00, 32'd0, "rst_ctrl");
        bus_read(8'h01, 32'd0, "rst_status");
        bus_read(8'h02, 32'd0, "rst_cnt");
        bus_read(8'h81, RST_VAL, "rst_shadow1");
        bus_read(8'h43, 32'd0, "rst_snap3");

        // Shadow write then software commit
        bus_write(8'h85, 32'h1234, 4'hF);
        bus_read(8'h85, 32'h1234, "shadow5");
        chk("oreg5_precommit", oreg_w(5), RST_VAL);
        bus_read(8'h01, 32'd1, "dirty_set");
        bus_write(8'h00, 32'h200, 4'hF);
        chk("oreg5_commit", oreg_w(5), 32'h1234);
        chk("upd_pulse", {31'd0, o_upd}, 32'd1);
        @(posedge clk_clk); #1;
        chk("upd_one_cycle", {31'd0, o_upd}, 32'd0);
        bus_read(8'h01, 32'd0, "dirty_clr");

        // Byte-lane write
        bus_write(8'h80, 32'hFFFF_FFFF, 4'hF);
        bus_write(8'h80, 32'h0000_0000, 4'h2);
        bus_read(8'h80, 32'hFFFF_00FF, "byteen");

        // Snapshot on sync, with action timing at edge k+3
        for (int i = 0; i < int'(N_VAR); i++) i_var[i*32 +: 32] = 32'h1000_0000 + i;
        i_var[3*32 +: 32] = 32'hA5A5;
        bus_write(8'h00, 32'h1, 4'hF);
        sync_to_k2();
        bus_read(8'h02, 32'd0, "cnt_at_k3");
        bus_read(8'h02, 32'd1, "cnt_after_k3");
        i_var[3*32 +: 32] = 32'h5A5A;
        bus_read(8'h43, 32'hA5A5, "snap3");
        bus_read(8'h47, 32'h1000_0007, "snap7");
        bus_read(8'h01, 32'd3, "fresh_set");
        bus_read(8'h01, 32'd1, "fresh_clr");
        sync_drop();
        bus_read(8'h02, 32'd1, "cnt_single");

        // STATUS read racing a snapshot keeps FRESH
        sync_to_k2();
        bus_read(8'h01, 32'd1, "race_status");
        bus_read(8'h01, 32'd3, "race_fresh_kept");
        bus_read(8'h01, 32'd1, "race_fresh_clr");
        bus_read(8'h43, 32'h5A5A, "snap3_second");
        sync_drop();

        // Shadow write racing a sync commit
        bus_write(8'h81, 32'h99, 4'hF);
        bus_write(8'h00, 32'h2, 4'hF);
        sync_to_k2();
        bus_write(8'h81, 32'h7, 4'hF);
        chk("race_oreg1_old", oreg_w(1), 32'h99);
        chk("race_oreg0", oreg_w(0), 32'hFFFF_00FF);
        chk("race_upd", {31'd0, o_upd}, 32'd1);
        bus_read(8'h81, 32'h7, "race_shadow1");
        bus_read(8'h01, 32'd1, "race_dirty");
        bus_read(8'h02, 32'd2, "cnt_no_snap");
        sync_drop();

        // Coinciding SW and sync triggers: one snapshot, one commit
        bus_write(8'h00, 32'h3, 4'hF);
        i_var[10*32 +: 32] = 32'h1010_2020;
        sync_to_k2();
        bus_write(8'h00, 32'h303, 4'hF);
        chk("both_upd", {31'd0, o_upd}, 32'd1);
        chk("both_oreg1", oreg_w(1), 32'h7);
        bus_read(8'h02, 32'd3, "both_cnt");
        bus_read(8'h4A, 32'h1010_2020, "both_snap10");
        bus_read(8'h00, 32'd3, "ctrl_pulse_rd0");
        bus_read(8'h01, 32'd2, "both_status");
        sync_drop();

        // Counter wrap after back-to-back software snapshots
        @(negedge clk_clk);
        avs_address = 8'h00; avs_writedata = 32'h100; avs_byteenable = 4'hF; avs_write = 1'b1;
        repeat (65533) @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
        bus_read(8'h02, 32'd0, "cnt_wrap");
        bus_read(8'h40 + 8'(N_VAR), 32'd0, "snap_oob");
        bus_write(8'h80 + 8'(N_VAR), 32'hFFFF_FFFF, 4'hF);
        bus_read(8'h80 + 8'(N_VAR), 32'd0, "shadow_oob");
        bus_read(8'h03, 32'd0, "unmapped");

        // Narrow build zero-extends and drops upper write bits
        bus_write(8'h82, 32'hDEAD_BEEF, 4'hF);
        bus_read(8'h82, 32'hDEAD_BEEF, "dw32_shadow2");
        chk("dw16_shadow2", rd16, 32'h0000_BEEF);

        // Reset in the middle of sync synchronisation
        bus_write(8'h00, 32'h3, 4'hF);
        bus_write(8'h85, 32'h5555, 4'hF);
        @(negedge clk_clk); sync_in = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk); reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_oreg5", oreg_w(5), RST_VAL);
        chk("mid_rst_oreg0", oreg_w(0), RST_VAL);
        chk("mid_rst_rdata", avs_readdata, 32'd0);
        chk("mid_rst_upd", {31'd0, o_upd}, 32'd0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_clk); #1;
            chk($sformatf("post_rst_upd%0d", c), {31'd0, o_upd}, 32'd0);
        end
        sync_in = 1'b0;
        bus_read(8'h00, 32'd0, "post_rst_ctrl");
        bus_read(8'h01, 32'd0, "post_rst_status");
        bus_read(8'h02, 32'd0, "post_rst_cnt");
        bus_read(8'h85, RST_VAL, "post_rst_shadow5");
        bus_read(8'h43, 32'd0, "post_rst_snap3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
